// File: rtl/fwd_result_pipe_pkg.sv
// Shared definitions for the result-staging pipe: packet layout macros and
// field offsets, execution-unit IDs, and the ready-stage helper.
// Packet layout, MSB first: {valid, unit, data, dst, lat, wr}.
`ifndef FWD_RESULT_PIPE_PKG_SV
`define FWD_RESULT_PIPE_PKG_SV

`define FRP_PKT_W(UW, DW, AW, LW) (1 + (UW) + (DW) + (AW) + (LW) + 1)
`define FRP_WR_BIT 0
`define FRP_LAT_LSB 1
`define FRP_DST_LSB(LW) (1 + (LW))
`define FRP_DATA_LSB(AW, LW) (1 + (LW) + (AW))
`define FRP_UNIT_LSB(DW, AW, LW) (1 + (LW) + (AW) + (DW))
`define FRP_VALID_BIT(UW, DW, AW, LW) (1 + (LW) + (AW) + (DW) + (UW))
`define FRP_PACK(V, U, D, A, L, W) {V, U, D, A, L, W}
`define FRP_FIELD(PKT, LSB, W) PKT[(LSB) +: (W)]

package fwd_result_pipe_pkg;

  // Offsets for the default widths (unit 3, data 128, addr 7, lat 4).
  localparam int DEF_UNIT_W = 3;
  localparam int DEF_DATA_W = 128;
  localparam int DEF_ADDR_W = 7;
  localparam int DEF_LAT_W  = 4;

  localparam int PKT_W        = `FRP_PKT_W(DEF_UNIT_W, DEF_DATA_W, DEF_ADDR_W, DEF_LAT_W);
  localparam int PKT_WR       = `FRP_WR_BIT;
  localparam int PKT_LAT_LSB  = `FRP_LAT_LSB;
  localparam int PKT_LAT_MSB  = PKT_LAT_LSB + DEF_LAT_W - 1;
  localparam int PKT_DST_LSB  = `FRP_DST_LSB(DEF_LAT_W);
  localparam int PKT_DST_MSB  = PKT_DST_LSB + DEF_ADDR_W - 1;
  localparam int PKT_DATA_LSB = `FRP_DATA_LSB(DEF_ADDR_W, DEF_LAT_W);
  localparam int PKT_DATA_MSB = PKT_DATA_LSB + DEF_DATA_W - 1;
  localparam int PKT_UNIT_LSB = `FRP_UNIT_LSB(DEF_DATA_W, DEF_ADDR_W, DEF_LAT_W);
  localparam int PKT_UNIT_MSB = PKT_UNIT_LSB + DEF_UNIT_W - 1;
  localparam int PKT_VALID    = `FRP_VALID_BIT(DEF_UNIT_W, DEF_DATA_W, DEF_ADDR_W, DEF_LAT_W);

  // Producing execution units.
  localparam logic [2:0] UNIT_PERM = 3'd0;
  localparam logic [2:0] UNIT_LS   = 3'd1;
  localparam logic [2:0] UNIT_BR   = 3'd2;
  localparam logic [2:0] UNIT_FX   = 3'd3;
  localparam logic [2:0] UNIT_FP   = 3'd4;
  localparam logic [2:0] UNIT_BYTE = 3'd5;

  // First stage number at which a result of the given latency is valid.
  function automatic int ready_stage(input int lat);
    return (lat < 1) ? 1 : lat;
  endfunction

endpackage

`endif

// File: rtl/fwd_result_pipe_lookup.sv
// Single-port forwarding search: youngest matching writer among the stages,
// then the write-back register. A not-yet-ready youngest writer reports
// pending and masks any older ready copy.
module fwd_lookup
  import fwd_result_pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 7,
  parameter int UNIT_W = 3,
  parameter int LAT_W  = 4,
  parameter int DEPTH  = 7,
  parameter int PKT_W  = `FRP_PKT_W(UNIT_W, DATA_W, ADDR_W, LAT_W)
) (
  input  logic [DEPTH*PKT_W-1:0] stage_bus,
  input  logic                   wb_en,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  input  logic [ADDR_W-1:0]      rd_addr,
  output logic                   hit,
  output logic                   pending,
  output logic [DATA_W-1:0]      data
);

  localparam int VALID_BIT = `FRP_VALID_BIT(UNIT_W, DATA_W, ADDR_W, LAT_W);
  localparam int UNIT_LSB  = `FRP_UNIT_LSB(DATA_W, ADDR_W, LAT_W);
  localparam int DATA_LSB  = `FRP_DATA_LSB(ADDR_W, LAT_W);
  localparam int DST_LSB   = `FRP_DST_LSB(LAT_W);
  localparam int LAT_LSB   = `FRP_LAT_LSB;
  localparam int WR_BIT    = `FRP_WR_BIT;

  logic [PKT_W-1:0] pkt;
  logic             unused_unit;

  // Walk oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit         = 1'b0;
    pending     = 1'b0;
    data        = '0;
    pkt         = '0;
    unused_unit = 1'b0;
    if (wb_en && (wb_addr == rd_addr)) begin
      hit  = 1'b1;
      data = wb_data;
    end
    for (int i = DEPTH - 1; i >= 0; i--) begin
      pkt = stage_bus[(DEPTH-i)*PKT_W-1 -: PKT_W];
      unused_unit = unused_unit ^ (^`FRP_FIELD(pkt, UNIT_LSB, UNIT_W));
      if (pkt[VALID_BIT] && pkt[WR_BIT] && (`FRP_FIELD(pkt, DST_LSB, ADDR_W) == rd_addr)) begin
        if ((i + 1) >= ready_stage(int'(`FRP_FIELD(pkt, LAT_LSB, LAT_W)))) begin
          hit     = 1'b1;
          pending = 1'b0;
          data    = `FRP_FIELD(pkt, DATA_LSB, DATA_W);
        end else begin
          hit     = 1'b0;
          pending = 1'b1;
          data    = '0;
        end
      end
    end
  end

endmodule

// File: rtl/fwd_result_pipe.sv
// Result-staging pipe: ages issued results through DEPTH stages, writes back
// from the last stage, forwards to NUM_RD readers and tracks occupancy.
// A flush discards the packets held in stages 1..FLUSH_STAGES together with
// the concurrent input; older packets keep advancing and write back.
module fwd_result_pipe
  import fwd_result_pipe_pkg::*;
#(
  parameter  int DATA_W       = 128,
  parameter  int ADDR_W       = 7,
  parameter  int UNIT_W       = 3,
  parameter  int LAT_W        = 4,
  parameter  int DEPTH        = 7,
  parameter  int FLUSH_STAGES = 2,
  parameter  int NUM_RD       = 3,
  parameter  int PKT_W        = `FRP_PKT_W(UNIT_W, DATA_W, ADDR_W, LAT_W),
  localparam int OCC_W        = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [UNIT_W-1:0]        in_unit,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [ADDR_W-1:0]        in_dst,
  input  logic [LAT_W-1:0]         in_lat,
  input  logic                     in_wr,
  output logic [DEPTH*PKT_W-1:0]   stage_pkt,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        fwd_hit,
  output logic [NUM_RD-1:0]        fwd_pending,
  output logic [NUM_RD*DATA_W-1:0] fwd_data,
  output logic                     wb_en,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data,
  output logic [OCC_W-1:0]         occupancy
);

  localparam int VALID_BIT = `FRP_VALID_BIT(UNIT_W, DATA_W, ADDR_W, LAT_W);
  localparam int DATA_LSB  = `FRP_DATA_LSB(ADDR_W, LAT_W);
  localparam int DST_LSB   = `FRP_DST_LSB(LAT_W);
  localparam int WR_BIT    = `FRP_WR_BIT;

  logic [PKT_W-1:0] stg [DEPTH];
  logic [PKT_W-1:0] in_pkt;
  logic [PKT_W-1:0] last_pkt;
  logic             kill_young;
  logic [OCC_W-1:0] flushed;
  logic [OCC_W-1:0] occ_next;

  assign in_pkt     = in_valid ? `FRP_PACK(1'b1, in_unit, in_data, in_dst, in_lat, in_wr) : '0;
  assign last_pkt   = stg[DEPTH-1];
  assign kill_young = flush && (FLUSH_STAGES > 0);

  // Stage shift: index k holds stage k+1; a flush zeroes every slot whose
  // source was the input or one of stages 1..FLUSH_STAGES.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= '0;
    end else begin
      stg[0] <= kill_young ? '0 : in_pkt;
      for (int k = 1; k < DEPTH; k++) begin
        stg[k] <= (kill_young && (k <= FLUSH_STAGES)) ? '0 : stg[k-1];
      end
    end
  end

  // Next occupancy: +accepted input, -packet leaving stage DEPTH, -packets
  // flushed from stages 1..FLUSH_STAGES (stage DEPTH leaves via write-back).
  always_comb begin
    flushed = '0;
    for (int k = 0; k < DEPTH - 1; k++) begin
      if (kill_young && (k < FLUSH_STAGES) && stg[k][VALID_BIT]) flushed = flushed + OCC_W'(1);
    end
    occ_next = occupancy + OCC_W'(in_valid && !kill_young)
               - OCC_W'(last_pkt[VALID_BIT]) - flushed;
  end

  // Registered write-back port and occupancy counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_en     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      occupancy <= '0;
    end else begin
      wb_en     <= last_pkt[VALID_BIT] && last_pkt[WR_BIT];
      wb_addr   <= `FRP_FIELD(last_pkt, DST_LSB, ADDR_W);
      wb_data   <= `FRP_FIELD(last_pkt, DATA_LSB, DATA_W);
      occupancy <= occ_next;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_flat
    assign stage_pkt[(DEPTH-i)*PKT_W-1 -: PKT_W] = stg[i];
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    fwd_lookup #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .UNIT_W (UNIT_W),
      .LAT_W  (LAT_W),
      .DEPTH  (DEPTH),
      .PKT_W  (PKT_W)
    ) u_lookup (
      .stage_bus (stage_pkt),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data),
      .rd_addr   (rd_addr[p*ADDR_W +: ADDR_W]),
      .hit       (fwd_hit[p]),
      .pending   (fwd_pending[p]),
      .data      (fwd_data[p*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_fwd_result_pipe.sv
// Bench for fwd_result_pipe: a default instance and a DEPTH=2 instance share
// one stimulus stream; a queue-of-packets model predicts every output.
module tb_fwd_result_pipe;

  localparam int DW = 128;
  localparam int AW = 7;
  localparam int UW = 3;
  localparam int LW = 4;
  localparam int PW = 1 + UW + DW + AW + LW + 1;
  localparam int DA = 7;
  localparam int FA = 2;
  localparam int NA = 3;
  localparam int DB = 2;
  localparam int FB = 2;
  localparam int NB = 1;

  // ---------------- clock / reset / stimulus signals ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [UW-1:0] in_unit = '0;
  logic [DW-1:0] in_data = '0;
  logic [AW-1:0] in_dst = '0;
  logic [LW-1:0] in_lat = '0;
  logic          in_wr = 1'b0;
  logic [NA*AW-1:0] rd_a = '0;
  logic [NB*AW-1:0] rd_b = '0;

  logic [DA*PW-1:0] a_stage;
  logic [NA-1:0]    a_hit, a_pend;
  logic [NA*DW-1:0] a_data;
  logic             a_wb_en;
  logic [AW-1:0]    a_wb_addr;
  logic [DW-1:0]    a_wb_data;
  logic [2:0]       a_occ;

  logic [DB*PW-1:0] b_stage;
  logic [NB-1:0]    b_hit, b_pend;
  logic [NB*DW-1:0] b_data;
  logic             b_wb_en;
  logic [AW-1:0]    b_wb_addr;
  logic [DW-1:0]    b_wb_data;
  logic [1:0]       b_occ;

  fwd_result_pipe #(.DEPTH(DA), .FLUSH_STAGES(FA), .NUM_RD(NA)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_unit(in_unit),
    .in_data(in_data), .in_dst(in_dst), .in_lat(in_lat), .in_wr(in_wr),
    .stage_pkt(a_stage), .rd_addr(rd_a), .fwd_hit(a_hit), .fwd_pending(a_pend),
    .fwd_data(a_data), .wb_en(a_wb_en), .wb_addr(a_wb_addr), .wb_data(a_wb_data),
    .occupancy(a_occ));

  fwd_result_pipe #(.DEPTH(DB), .FLUSH_STAGES(FB), .NUM_RD(NB)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_unit(in_unit),
    .in_data(in_data), .in_dst(in_dst), .in_lat(in_lat), .in_wr(in_wr),
    .stage_pkt(b_stage), .rd_addr(rd_b), .fwd_hit(b_hit), .fwd_pending(b_pend),
    .fwd_data(b_data), .wb_en(b_wb_en), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
    .occupancy(b_occ));

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  typedef struct {
    bit            v;
    logic [UW-1:0] unit;
    logic [DW-1:0] data;
    logic [AW-1:0] dst;
    logic [LW-1:0] lat;
    bit            wr;
  } pkt_t;

  pkt_t mstg [2][16];
  pkt_t mwb  [2];
  int   mdepth [2] = '{DA, DB};
  int   mfs    [2] = '{FA, FB};

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 0;

  function automatic pkt_t empty_pkt();
    pkt_t p;
    p.v = 0; p.unit = '0; p.data = '0; p.dst = '0; p.lat = '0; p.wr = 0;
    return p;
  endfunction

  function automatic logic [PW-1:0] pack(pkt_t p);
    return {p.v, p.unit, p.data, p.dst, p.lat, p.wr};
  endfunction

  // One clock edge of the pipe as a list of in-flight packets.
  function automatic void model_step(int n);
    int d = mdepth[n];
    int fs = mfs[n];
    if (!rst_n) begin
      for (int j = 0; j < 16; j++) mstg[n][j] = empty_pkt();
      mwb[n] = empty_pkt();
      return;
    end
    mwb[n] = mstg[n][d-1];
    for (int j = d - 1; j > 0; j--) mstg[n][j] = mstg[n][j-1];
    mstg[n][0] = empty_pkt();
    if (in_valid) begin
      mstg[n][0].v = 1; mstg[n][0].unit = in_unit; mstg[n][0].data = in_data;
      mstg[n][0].dst = in_dst; mstg[n][0].lat = in_lat; mstg[n][0].wr = in_wr;
    end
    // The new input and the packets from stages 1..fs are wrong-path; after
    // the shift they sit in slots 0..fs.
    if (flush && fs > 0) begin
      for (int j = 0; j <= fs && j < d; j++) mstg[n][j] = empty_pkt();
    end
  endfunction

  function automatic int model_occ(int n);
    int c = 0;
    for (int j = 0; j < mdepth[n]; j++) if (mstg[n][j].v) c++;
    return c;
  endfunction

  task automatic model_lookup(input int n, input logic [AW-1:0] rd,
                              output bit hit, output bit pend, output logic [DW-1:0] data);
    int need;
    hit = 0; pend = 0; data = '0;
    for (int j = 0; j < mdepth[n]; j++) begin
      if (mstg[n][j].v && mstg[n][j].wr && mstg[n][j].dst == rd) begin
        need = (mstg[n][j].lat == 0) ? 1 : int'(mstg[n][j].lat);
        if (j + 1 >= need) begin hit = 1; data = mstg[n][j].data; end
        else pend = 1;
        return;
      end
    end
    if (mwb[n].v && mwb[n].wr && mwb[n].dst == rd) begin
      hit = 1; data = mwb[n].data;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step(0);
    model_step(1);
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    bit h, pd;
    logic [DW-1:0] dt;
    for (int j = 0; j < DA; j++)
      chk($sformatf("a_stage%0d", j + 1), 256'(a_stage[(DA-j)*PW-1 -: PW]), 256'(pack(mstg[0][j])));
    chk("a_wb_en", 256'(a_wb_en), 256'(mwb[0].v & mwb[0].wr));
    chk("a_wb_addr", 256'(a_wb_addr), 256'(mwb[0].dst));
    chk("a_wb_data", 256'(a_wb_data), 256'(mwb[0].data));
    chk("a_occ", 256'(a_occ), 256'(model_occ(0)));
    for (int p = 0; p < NA; p++) begin
      model_lookup(0, rd_a[p*AW +: AW], h, pd, dt);
      chk($sformatf("a_hit%0d", p), 256'(a_hit[p]), 256'(h));
      chk($sformatf("a_pend%0d", p), 256'(a_pend[p]), 256'(pd));
      chk($sformatf("a_data%0d", p), 256'(a_data[p*DW +: DW]), 256'(dt));
    end
    for (int j = 0; j < DB; j++)
      chk($sformatf("b_stage%0d", j + 1), 256'(b_stage[(DB-j)*PW-1 -: PW]), 256'(pack(mstg[1][j])));
    chk("b_wb_en", 256'(b_wb_en), 256'(mwb[1].v & mwb[1].wr));
    chk("b_wb_addr", 256'(b_wb_addr), 256'(mwb[1].dst));
    chk("b_wb_data", 256'(b_wb_data), 256'(mwb[1].data));
    chk("b_occ", 256'(b_occ), 256'(model_occ(1)));
    model_lookup(1, rd_b, h, pd, dt);
    chk("b_hit", 256'(b_hit[0]), 256'(h));
    chk("b_pend", 256'(b_pend[0]), 256'(pd));
    chk("b_data", 256'(b_data), 256'(dt));
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) compare_all();
  end

  // ---------------- driver tasks ----------------
  task automatic step(input bit v, input logic [AW-1:0] dst, input logic [DW-1:0] data,
                      input logic [LW-1:0] lat, input bit wr, input bit fl);
    in_valid = v; in_dst = dst; in_data = data; in_lat = lat; in_wr = wr; flush = fl;
    in_unit = UW'($urandom_range(0, 7));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, '0, '0, '0, 0, 0);
  endtask

  function automatic logic [PW-1:0] a_stg(int k);
    return a_stage[(DA-k+1)*PW-1 -: PW];
  endfunction

  // ---------------- directed + random sequence ----------------
  logic [DW-1:0] aa;
  logic [PW-1:0] s;
  bit            exp_hit;

  initial begin
    aa = {16{8'hAA}};
    rst_n = 0;
    idle(1);
    chk_en = 1;
    idle(1);
    chk("reset_occ", 256'(a_occ), 256'(0));
    chk("reset_wb_en", 256'(a_wb_en), 256'(0));
    chk("reset_stage_any", 256'(|a_stage), 256'(0));
    rst_n = 1;

    // Basic flow: dst 5, lat 2.
    step(1, 7'd5, aa, 4'd2, 1, 0);
    chk("basic_s1_valid", 256'(a_stage[DA*PW-1]), 256'(1));
    chk("basic_occ1", 256'(a_occ), 256'(1));
    idle(6);
    s = a_stg(7);
    chk("basic_s7_dst", 256'(s[11:5]), 256'(5));
    chk("basic_wb_early", 256'(a_wb_en), 256'(0));
    idle(1);
    chk("basic_wb_en", 256'(a_wb_en), 256'(1));
    chk("basic_wb_addr", 256'(a_wb_addr), 256'(5));
    chk("basic_wb_data", 256'(a_wb_data), 256'(aa));
    chk("basic_occ0", 256'(a_occ), 256'(0));

    // Pending then hit: lat 4, looked up on port 0.
    rd_a = {7'd0, 7'd0, 7'd5};
    for (int k = 1; k <= 8; k++) begin
      if (k == 1) step(1, 7'd5, aa, 4'd4, 1, 0);
      else idle(1);
      exp_hit = (k >= 4);
      chk($sformatf("pend_hit_k%0d", k), 256'(a_hit[0]), 256'(exp_hit));
      chk($sformatf("pend_pend_k%0d", k), 256'(a_pend[0]), 256'(!exp_hit));
      chk($sformatf("pend_data_k%0d", k), 256'(a_data[DW-1:0]), exp_hit ? 256'(aa) : 256'(0));
    end
    idle(2);

    // Youngest wins: older ready copy is masked by the pending younger one.
    rd_a = {7'd0, 7'd0, 7'd9};
    step(1, 7'd9, 128'd1, 4'd1, 1, 0);
    chk("young_first_hit", 256'(a_hit[0]), 256'(1));
    chk("young_first_data", 256'(a_data[DW-1:0]), 256'(1));
    step(1, 7'd9, 128'd2, 4'd6, 1, 0);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) idle(1);
      chk($sformatf("young_hit_k%0d", k), 256'(a_hit[0]), 256'(k == 6));
      chk($sformatf("young_pend_k%0d", k), 256'(a_pend[0]), 256'(k != 6));
      chk($sformatf("young_data_k%0d", k), 256'(a_data[DW-1:0]), 256'((k == 6) ? 2 : 0));
    end
    idle(8);

    // Flush with concurrent input: occupancy 4 -> 2, dst 10/11 still write back.
    for (int i = 0; i < 4; i++) step(1, 7'(10 + i), 128'(100 + i), 4'd1, 1, 0);
    chk("flush_occ4", 256'(a_occ), 256'(4));
    step(1, 7'd14, 128'd99, 4'd1, 1, 1);
    chk("flush_occ2", 256'(a_occ), 256'(2));
    s = a_stg(1);
    chk("flush_s1_valid", 256'(s[PW-1]), 256'(0));
    s = a_stg(4);
    chk("flush_s4_dst", 256'(s[11:5]), 256'(11));
    idle(3);
    chk("flush_wb10_en", 256'(a_wb_en), 256'(1));
    chk("flush_wb10_addr", 256'(a_wb_addr), 256'(10));
    idle(1);
    chk("flush_wb11_addr", 256'(a_wb_addr), 256'(11));
    chk("flush_occ_end", 256'(a_occ), 256'(0));
    idle(1);
    chk("flush_wb_done", 256'(a_wb_en), 256'(0));
    idle(2);

    // Reset mid-stream.
    rd_a = {7'd22, 7'd21, 7'd20};
    for (int i = 0; i < 5; i++) step(1, 7'(20 + i % 3), 128'(i + 1), 4'(i % 3), 1, 0);
    rst_n = 0;
    idle(1);
    chk("rst_stage_any", 256'(|a_stage), 256'(0));
    chk("rst_wb_en", 256'(a_wb_en), 256'(0));
    chk("rst_wb_addr", 256'(a_wb_addr), 256'(0));
    chk("rst_wb_data", 256'(a_wb_data), 256'(0));
    chk("rst_occ", 256'(a_occ), 256'(0));
    chk("rst_hit", 256'(a_hit), 256'(0));
    chk("rst_pend", 256'(a_pend), 256'(0));
    chk("rst_b_occ", 256'(b_occ), 256'(0));
    rst_n = 1;
    for (int i = 0; i < 9; i++) begin
      idle(1);
      chk("rst_no_wb", 256'(a_wb_en), 256'(0));
    end

    // DEPTH=2 instance: lat 15 is pending in both stages, hits from write-back.
    rd_b = 7'd30;
    rd_a = {7'd0, 7'd0, 7'd30};
    step(1, 7'd30, 128'd5, 4'd15, 1, 0);
    chk("sweep_pend_s1", 256'(b_pend[0]), 256'(1));
    chk("sweep_hit_s1", 256'(b_hit[0]), 256'(0));
    idle(1);
    chk("sweep_pend_s2", 256'(b_pend[0]), 256'(1));
    chk("sweep_hit_s2", 256'(b_hit[0]), 256'(0));
    idle(1);
    chk("sweep_hit_wb", 256'(b_hit[0]), 256'(1));
    chk("sweep_pend_wb", 256'(b_pend[0]), 256'(0));
    chk("sweep_data_wb", 256'(b_data), 256'(5));
    chk("sweep_a_pend_s3", 256'(a_pend[0]), 256'(1));
    idle(8);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      rd_a = {7'($urandom_range(0, 7)), 7'($urandom_range(0, 7)), 7'($urandom_range(0, 7))};
      rd_b = 7'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 99) != 0);
      step($urandom_range(0, 3) != 0, 7'($urandom_range(0, 7)),
           {$urandom, $urandom, $urandom, $urandom}, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end
    rst_n = 1;
    idle(10);

    @(negedge clk);
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
